// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode constants, queued command record, FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  typedef struct packed {
    logic        a_or_l;
    logic        s_or_u;
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  // Arithmetic MUL/DIV need the Alu to settle for extra cycles.
  function automatic logic is_muldiv(input logic a_or_l, input logic [2:0] opcode);
    return !a_or_l && (opcode == OP_MUL || opcode == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for the ALU sequencer: power-of-two depth, wrapping pointers,
// simultaneous push and pop allowed; pushes while full and pops while empty are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, issues them one at a time to an external Alu and returns results.
// Optional macro ALU_SEQ_DIVZERO_EN: arithmetic DIV by zero answers 0 with rsp_err set, without waiting.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MULDIV_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_a_or_l,
  input  logic        cmd_s_or_u,
  input  logic [2:0]  cmd_opcode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_a_or_l,
  output logic        alu_s_or_u,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_answer,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CNT_W = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MULDIV_WAIT > 0) ? MULDIV_WAIT - 1 : 0);

  seq_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  alu_cmd_t         push_cmd;
  alu_cmd_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             div_zero;

  assign push_cmd  = '{a_or_l: cmd_a_or_l, s_or_u: cmd_s_or_u, opcode: cmd_opcode,
                       a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

`ifdef ALU_SEQ_DIVZERO_EN
  assign div_zero = !alu_a_or_l && (alu_opcode == OP_DIV) && (alu_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_a_or_l <= 1'b0;
      alu_s_or_u <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a_or_l <= head.a_or_l;
            alu_s_or_u <= head.s_or_u;
            alu_opcode <= head.opcode;
            alu_a      <= head.a;
            alu_b      <= head.b;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!div_zero && is_muldiv(alu_a_or_l, alu_opcode) && MULDIV_WAIT > 0) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            // Without the div-zero option div_zero is tied low, so rsp_err never leaves 0.
            rsp_data  <= div_zero ? '0 : alu_answer;
            rsp_err   <= div_zero;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            rsp_data  <= alu_answer;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
